// File: rtl/run_harness_pkg.sv
// Shared state encodings and launch-mode constants for the run harness controller.
package run_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_SEQ  = 1'b0;
    localparam logic MODE_CONC = 1'b1;

endpackage

// File: rtl/run_harness_chan.sv
// One core channel: run request, saturating run-length counter and capture registers.
module run_harness_chan #(
    parameter int unsigned RW = 32,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          launch,
    input  logic          abort,
    input  logic          fin_en,
    input  logic          finish,
    input  logic [RW-1:0] result_in,
    output logic          run_req,
    output logic [RW-1:0] result_out,
    output logic [CW-1:0] cyc_out,
    output logic          fin_c
);

    logic          run_req_q, run_req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] res_q, res_d;
    logic [CW-1:0] cyc_q, cyc_d;

    // A finish only counts while this channel is actually being run.
    assign fin_c = run_req_q & finish & fin_en;

    always_comb begin
        run_req_d = run_req_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        cyc_d     = cyc_q;
        if (clear) begin
            run_req_d = 1'b0;
            cnt_d     = '0;
            res_d     = '0;
            cyc_d     = '0;
        end else begin
            if (fin_c) begin
                res_d     = result_in;
                cyc_d     = cnt_q;
                run_req_d = 1'b0;
            end else if (run_req_q && (cnt_q != '1)) begin
                cnt_d = cnt_q + CW'(1);
            end
            // Counter holds the number of cycles run_req has been high so far.
            if (launch) begin
                run_req_d = 1'b1;
                cnt_d     = CW'(1);
            end
            if (abort) begin
                run_req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_req_q <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
            cyc_q     <= '0;
        end else begin
            run_req_q <= run_req_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            cyc_q     <= cyc_d;
        end
    end

    assign run_req    = run_req_q;
    assign result_out = res_q;
    assign cyc_out    = cyc_q;

endmodule

// File: rtl/run_harness_ctrl.sv
// Run controller for generated method cores: reset hold, sequential/concurrent launch, capture, done.
// Optional watchdog is built in when RUN_HARNESS_TIMEOUT_EN is defined.
module run_harness_ctrl
    import run_harness_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned RW       = 32,
    parameter int unsigned CW       = 32,
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [NCH-1:0]    ch_en,
    output logic              core_reset,
    output logic [NCH-1:0]    run_req,
    input  logic [NCH-1:0]    finish_flag,
    input  logic [NCH*RW-1:0] result_in,
    output logic [NCH*RW-1:0] result_out,
    output logic [NCH*CW-1:0] cyc_out,
    output logic              done,
    output logic              timeout
);

    localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_e         state_q, state_d;
    logic           mode_q, mode_d;
    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           core_reset_q, core_reset_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;

    logic           clear_c;
    logic           abort_c;
    logic           run_en_c;
    logic           wd_fire_c;
    logic [NCH-1:0] launch_c;
    logic [NCH-1:0] fin_c;
    logic [NCH-1:0] left_c;
    logic [NCH-1:0] first_c;
    logic [NCH-1:0] next_c;

    assign run_en_c = (state_q == ST_RUN);
    assign left_c   = pend_q & ~fin_c;
    // Isolate the lowest set bit: lowest enabled channel / lowest channel still owed a run.
    assign first_c  = en_q & (~en_q + NCH'(1));
    assign next_c   = left_c & (~left_c + NCH'(1));

`ifdef RUN_HARNESS_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (state_q == ST_HOLD) begin
            wd_d = '0;
        end else if ((state_q == ST_RUN) && (wd_q != TW'(TIMEOUT - 1))) begin
            wd_d = wd_q + TW'(1);
        end
    end

    assign wd_fire_c = (state_q == ST_RUN) && (wd_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |32'(TIMEOUT);
    assign wd_fire_c      = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        en_d      = en_q;
        pend_d    = pend_q;
        hold_d    = hold_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        clear_c   = 1'b0;
        abort_c   = 1'b0;
        launch_c  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_HOLD;
                    mode_d    = mode;
                    en_d      = ch_en;
                    hold_d    = HW'(RST_HOLD - 1);
                    clear_c   = 1'b1;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    pend_d = en_q;
                    if (en_q == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        launch_c = (mode_q == MODE_CONC) ? en_q : first_c;
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            ST_RUN: begin
                pend_d = left_c;
                if (left_c == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (wd_fire_c) begin
                    abort_c   = 1'b1;
                    pend_d    = '0;
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if ((mode_q == MODE_SEQ) && (fin_c != '0)) begin
                    launch_c = next_c;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_reset_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_SEQ;
            en_q         <= '0;
            pend_q       <= '0;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            en_q         <= en_d;
            pend_q       <= pend_d;
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        run_harness_chan #(
            .RW(RW),
            .CW(CW)
        ) u_chan (
            .clk        (clk),
            .rst_n      (reset),
            .clear      (clear_c),
            .launch     (launch_c[i]),
            .abort      (abort_c),
            .fin_en     (run_en_c),
            .finish     (finish_flag[i]),
            .result_in  (result_in[i*RW +: RW]),
            .run_req    (run_req[i]),
            .result_out (result_out[i*RW +: RW]),
            .cyc_out    (cyc_out[i*CW +: CW]),
            .fin_c      (fin_c[i])
        );
    end

    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule
